// File: rtl/uart_tx_arbiter_if.sv
// Request/grant and transmit-data bundle between the byte sources, the arbiter and the UART transmitter.
// master = arbiter side, slave = requesters/transmitter side.
interface uart_tx_arbiter_if #(
    parameter int NREQ = 4,
    parameter int RRW  = 3
);
    logic                 en;
    logic [NREQ-1:0]      req;
    logic [8*NREQ-1:0]    req_data;
    logic [NREQ-1:0]      ack;
    logic [7:0]           DATA;
    logic                 tx_valid;
    logic [RRW-1:0]       src;
    logic                 frame_start;

    modport master (
        input  en, req, req_data,
        output ack, DATA, tx_valid, src, frame_start
    );

    modport slave (
        output en, req, req_data,
        input  ack, DATA, tx_valid, src, frame_start
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding a free-running 10-bit-frame UART transmitter, one grant per frame.
// Optional macro UART_TX_ARB_PRIO_EN makes source 0 strict-priority over the round robin.
module uart_tx_arbiter #(
    parameter int          NREQ      = 4,
    parameter logic [7:0]  FILL_BYTE = 8'hFF,
    parameter int          RRW       = 3
) (
    input logic                 Div_CLK,
    input logic                 RST,
    uart_tx_arbiter_if.master   bus
);

    logic [3:0]      phase_q, phase_d;
    logic [7:0]      data_q, data_d;
    logic [RRW-1:0]  src_q, src_d;
    logic [RRW-1:0]  rr_ptr_q, rr_ptr_d;
    logic            tx_valid_q, tx_valid_d;
    logic [NREQ-1:0] ack_q, ack_d;

    logic [NREQ-1:0] eligible;
    logic [RRW-1:0]  grant;
    logic            found;
    int              idx;

    // Upward search from rr_ptr, wrapping modulo NREQ (which need not be a power of two).
    always_comb begin
        eligible = bus.req & {NREQ{bus.en}};
        found    = 1'b0;
        grant    = '0;
        idx      = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && eligible[idx]) begin
                found = 1'b1;
                grant = RRW'(idx);
            end
        end
`ifdef UART_TX_ARB_PRIO_EN
        if (eligible[0]) begin
            found = 1'b1;
            grant = '0;
        end
`endif
    end

    always_comb begin
        phase_d    = (phase_q == 4'd9) ? 4'd0 : phase_q + 4'd1;
        data_d     = data_q;
        src_d      = src_q;
        rr_ptr_d   = rr_ptr_q;
        tx_valid_d = tx_valid_q;
        ack_d      = '0;
        // DATA may only change on the stop-bit edge so the transmitter sees a stable byte.
        if (phase_q == 4'd9) begin
            if (found) begin
                data_d     = bus.req_data[8*grant +: 8];
                src_d      = grant;
                tx_valid_d = 1'b1;
                ack_d      = NREQ'(1) << grant;
                rr_ptr_d   = (grant == RRW'(NREQ-1)) ? '0 : grant + RRW'(1);
`ifdef UART_TX_ARB_PRIO_EN
                if (eligible[0]) rr_ptr_d = rr_ptr_q;
`endif
            end else begin
                data_d     = FILL_BYTE;
                tx_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge Div_CLK or posedge RST) begin
        if (RST) begin
            phase_q    <= '0;
            data_q     <= FILL_BYTE;
            src_q      <= '0;
            rr_ptr_q   <= '0;
            tx_valid_q <= 1'b0;
            ack_q      <= '0;
        end else begin
            phase_q    <= phase_d;
            data_q     <= data_d;
            src_q      <= src_d;
            rr_ptr_q   <= rr_ptr_d;
            tx_valid_q <= tx_valid_d;
            ack_q      <= ack_d;
        end
    end

    assign bus.DATA        = data_q;
    assign bus.src         = src_q;
    assign bus.tx_valid    = tx_valid_q;
    assign bus.ack         = ack_q;
    assign bus.frame_start = (phase_q == 4'd0);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter; the frame phase is tracked independently here.
// Build with +define+UART_TX_ARB_PRIO_EN to exercise the strict-priority variant.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int RRW  = 3;

    logic Div_CLK = 1'b0;
    logic RST;

    uart_tx_arbiter_if #(.NREQ(NREQ), .RRW(RRW)) bus ();

    uart_tx_arbiter #(.NREQ(NREQ), .FILL_BYTE(8'hFF), .RRW(RRW)) dut (
        .Div_CLK (Div_CLK),
        .RST     (RST),
        .bus     (bus)
    );

    always #5 Div_CLK = ~Div_CLK;

    int passCount  = 0;
    int checkCount = 0;
    int failCount  = 0;
    int tbPhase    = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h (failure #%0d)", tag, observed, expected, failCount);
        end
    endtask

    task automatic checkFrame(input string tag, input logic [7:0] expData, input logic expValid,
                              input int expSrc, input logic [NREQ-1:0] expAck);
        checkOutput({tag, "_data"},  32'(bus.DATA),        32'(expData));
        checkOutput({tag, "_valid"}, 32'(bus.tx_valid),    32'(expValid));
        checkOutput({tag, "_src"},   32'(bus.src),         32'(expSrc));
        checkOutput({tag, "_ack"},   32'(bus.ack),         32'(expAck));
        checkOutput({tag, "_fs"},    32'(bus.frame_start), 32'(tbPhase == 0));
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] reqV, input logic [8*NREQ-1:0] bytesV);
        bus.req      = reqV;
        bus.req_data = bytesV;
    endtask

    task automatic tick();
        @(posedge Div_CLK);
        #1;
        if (RST) tbPhase = 0;
        else     tbPhase = (tbPhase == 9) ? 0 : tbPhase + 1;
    endtask

    task automatic runToPhase(input int p);
        do tick(); while (tbPhase != p);
    endtask

    function automatic logic lineBit();
        if (tbPhase == 0) return 1'b0;
        if (tbPhase == 9) return 1'b1;
        return bus.DATA[tbPhase-1];
    endfunction

    logic [9:0]  expBits = 10'b1101001010;
    logic [31:0] fourBytes = 32'h44332211;
    int          order[4];

    initial begin
        RST = 1'b1;
        bus.en = 1'b1;
        applyStimulus('0, '0);
        repeat (3) tick();
        checkFrame("reset", 8'hFF, 1'b0, 0, 4'b0000);
        RST = 1'b0;

        // Idle: only fill frames, frame_start every 10 cycles
        for (int c = 1; c <= 30; c++) begin
            tick();
            checkOutput("idle_data", 32'(bus.DATA), 32'hFF);
            checkOutput("idle_valid", 32'(bus.tx_valid), 32'd0);
            checkOutput("idle_ack", 32'(bus.ack), 32'd0);
            checkOutput("idle_fs", 32'(bus.frame_start), 32'(c % 10 == 0));
        end

        // Single requester, serial line image of 8'hA5
        applyStimulus(4'b0010, 32'h0000A500);
        repeat (9) tick();
        checkFrame("pre_grant", 8'hFF, 1'b0, 0, 4'b0000);
        tick();
        checkFrame("grant1", 8'hA5, 1'b1, 1, 4'b0010);
        for (int p = 0; p < 10; p++) begin
            checkOutput("serial", 32'(lineBit()), 32'(expBits[tbPhase]));
            checkOutput("stable", 32'(bus.DATA), 32'hA5);
            if (p != 0) checkOutput("ack_pulse", 32'(bus.ack), 32'd0);
            tick();
        end
        checkFrame("grant1b", 8'hA5, 1'b1, 1, 4'b0010);

        // All requesting: pointer now at 2 -> 2,3,0,1,2
        applyStimulus(4'b1111, fourBytes);
        for (int f = 0; f < 5; f++) begin
            int s;
            s = (2 + f) % 4;
            repeat (10) tick();
            checkFrame("rr", 8'((s + 1) * 17), 1'b1, s, 4'(1 << s));
        end

        // Request pulse missing the phase-9 edge is ignored; src holds
        applyStimulus(4'b0000, fourBytes);
        runToPhase(3);
        bus.req = 4'b0100;
        runToPhase(7);
        bus.req = 4'b0000;
        runToPhase(0);
        checkFrame("pulse", 8'hFF, 1'b0, 2, 4'b0000);

        // Reset mid-frame while source 1 is sending; pointer must restart at 0
        applyStimulus(4'b0010, 32'h0000A500);
        runToPhase(0);
        checkFrame("pre_rst", 8'hA5, 1'b1, 1, 4'b0010);
        runToPhase(5);
        RST = 1'b1;
        #1;
        tbPhase = 0;
        checkFrame("rst_async", 8'hFF, 1'b0, 0, 4'b0000);
        tick();
        tick();
        RST = 1'b0;
        applyStimulus(4'b1111, fourBytes);
        repeat (9) tick();
        checkFrame("rst_fill", 8'hFF, 1'b0, 0, 4'b0000);
        tick();
        checkFrame("rst_first", 8'h11, 1'b1, 0, 4'b0001);

        // en falling mid-frame keeps the current frame, next frame is fill
        runToPhase(4);
        bus.en = 1'b0;
        runToPhase(8);
        checkFrame("en_hold", 8'h11, 1'b1, 0, 4'b0000);
        runToPhase(0);
        checkFrame("en_off", 8'hFF, 1'b0, 0, 4'b0000);
        bus.en = 1'b1;
        runToPhase(0);
        checkFrame("en_on", 8'h22, 1'b1, 1, 4'b0010);

        // Fresh pointer, req = 1011
        RST = 1'b1;
        tick();
        RST = 1'b0;
        applyStimulus(4'b1011, fourBytes);
`ifdef UART_TX_ARB_PRIO_EN
        for (int f = 0; f < 3; f++) begin
            repeat (10) tick();
            checkFrame("prio0", 8'h11, 1'b1, 0, 4'b0001);
        end
        bus.req = 4'b1010;
        order = '{1, 3, 1, 3};
`else
        order = '{0, 1, 3, 0};
`endif
        for (int f = 0; f < 4; f++) begin
            repeat (10) tick();
            checkFrame("rr1011", 8'((order[f] + 1) * 17), 1'b1, order[f], 4'(1 << order[f]));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
